ucsbece154_fetch: RTL and testbench

//  Dual-wide instruction fetch front end; drives both ports of the two-port instruction memory.

---
 rtl/ucsbece154_fetch_pkg.sv | 19 +
 rtl/ucsbece154_fetch_queue.sv | 69 ++++++
 rtl/ucsbece154_fetch.sv | 86 ++++++++
 tb/tb_ucsbece154_fetch.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ucsbece154_fetch_pkg.sv
// Shared types and constants for the dual-wide fetch front end.
// Queue entries carry the fetch PC alongside the instruction word.
package ucsbece154_fetch_pkg;

  localparam int unsigned        INSTR_W          = 32;
  localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0001_0000;
  localparam int unsigned        ENTRY_W          = 2 * INSTR_W;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Decode can pop at most two entries; an encoding of 3 means "as many as possible".
  function automatic logic [1:0] sat_deq(input logic [1:0] d);
    return (d == 2'd3) ? 2'd2 : d;
  endfunction

endpackage

// File: rtl/ucsbece154_fetch_queue.sv
// In-order circular buffer with two write ports (always used as a pair) and
// two combinational read ports at head and head+1.
module ucsbece154_fetch_queue
  import ucsbece154_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data1_i,
  input  logic [WIDTH-1:0]           wr_data2_i,
  input  logic [1:0]                 rd_cnt_i,
  output logic [WIDTH-1:0]           rd_data1_o,
  output logic [WIDTH-1:0]           rd_data2_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    tail_p1, head_p1;
  logic             wr;

  assign wr      = wr_en_i && !flush_i;
  assign tail_p1 = tail_q + PW'(1);
  assign head_p1 = head_q + PW'(1);

  // Storage is deliberately not reset; entries beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[tail_q]  <= wr_data1_i;
      mem_q[tail_p1] <= wr_data2_i;
    end
  end

  always_comb begin
    head_d  = head_q + PW'(rd_cnt_i);
    tail_d  = wr ? (tail_q + PW'(2)) : tail_q;
    count_d = count_q - CW'(rd_cnt_i) + (wr ? CW'(2) : CW'(0));
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_data1_o = mem_q[head_q];
  assign rd_data2_o = mem_q[head_p1];
  assign count_o    = count_q;

endmodule

// File: rtl/ucsbece154_fetch.sv
// Dual-wide fetch: presents PC and PC+4 to the two-port imem, queues both
// words with their PCs, and restarts from redirect_pc_i on a redirect.
module ucsbece154_fetch
  import ucsbece154_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_i,
  input  logic [31:0]                   redirect_pc_i,
  output logic [31:0]                   imem_a1_o,
  output logic [31:0]                   imem_a2_o,
  input  logic [31:0]                   imem_rd1_i,
  input  logic [31:0]                   imem_rd2_i,
  input  logic [1:0]                    deq_cnt_i,
  output logic [31:0]                   instr1_o,
  output logic [31:0]                   pc1_o,
  output logic                          valid1_o,
  output logic [31:0]                   instr2_o,
  output logic [31:0]                   pc2_o,
  output logic                          valid2_o,
  output logic [$clog2(QUEUE_DEPTH):0]  count_o
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  pc_q, pc_d;
  logic [CW-1:0] count;
  logic          fetch;
  logic [1:0]    deq_sat, deq_eff;
  fetch_entry_t  wr1, wr2, rd1, rd2;

  // Registered count only: a same-cycle dequeue does not free room for a fetch.
  assign fetch   = !redirect_i && (count <= CW'(QUEUE_DEPTH - 2));
  assign deq_sat = sat_deq(deq_cnt_i);

  always_comb begin
    deq_eff = deq_sat;
    if (CW'(deq_sat) > count) deq_eff = count[1:0];
    if (redirect_i)           deq_eff = 2'd0;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_i)  pc_d = redirect_pc_i & ~32'd3;
    else if (fetch)  pc_d = pc_q + 32'd8;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign imem_a1_o = pc_q;
  assign imem_a2_o = pc_q + 32'd4;

  assign wr1 = '{pc: imem_a1_o, instr: imem_rd1_i};
  assign wr2 = '{pc: imem_a2_o, instr: imem_rd2_i};

  ucsbece154_fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_i),
    .wr_en_i    (fetch),
    .wr_data1_i (wr1),
    .wr_data2_i (wr2),
    .rd_cnt_i   (deq_eff),
    .rd_data1_o (rd1),
    .rd_data2_o (rd2),
    .count_o    (count)
  );

  assign instr1_o = rd1.instr;
  assign pc1_o    = rd1.pc;
  assign instr2_o = rd2.instr;
  assign pc2_o    = rd2.pc;
  assign valid1_o = (count != '0);
  assign valid2_o = (count >= CW'(2));
  assign count_o  = count;

endmodule

// File: tb/tb_ucsbece154_fetch.sv
// Directed bench for the dual-wide fetch: imem is a combinational address hash,
// expected PCs and counts are worked out by hand for QUEUE_DEPTH = 4.
module tb_ucsbece154_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_a1_o, imem_a2_o, imem_rd1_i, imem_rd2_i;
  logic [1:0]  deq_cnt_i;
  logic [31:0] instr1_o, pc1_o, instr2_o, pc2_o;
  logic        valid1_o, valid2_o;
  logic [2:0]  count_o;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  assign imem_rd1_i = word_at(imem_a1_o);
  assign imem_rd2_i = word_at(imem_a2_o);

  always #5 clk = ~clk;

  ucsbece154_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0001_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_a1_o     (imem_a1_o),
    .imem_a2_o     (imem_a2_o),
    .imem_rd1_i    (imem_rd1_i),
    .imem_rd2_i    (imem_rd2_i),
    .deq_cnt_i     (deq_cnt_i),
    .instr1_o      (instr1_o),
    .pc1_o         (pc1_o),
    .valid1_o      (valid1_o),
    .instr2_o      (instr2_o),
    .pc2_o         (pc2_o),
    .valid2_o      (valid2_o),
    .count_o       (count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges; outputs must react without a clock.
  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_valid1"}, {31'd0, valid1_o}, 32'd0);
    check({tag, "_count"},  {29'd0, count_o},  32'd0);
    check({tag, "_a1"},     imem_a1_o,         32'h0001_0000);
    check({tag, "_a2"},     imem_a2_o,         32'h0001_0004);
    #1 reset = 1'b0;
  endtask

  task automatic check_q(input string tag, input int cnt, input logic [31:0] p1, input logic [31:0] p2);
    check({tag, "_count"}, {29'd0, count_o}, cnt);
    if (cnt >= 1) begin
      check({tag, "_pc1"},    pc1_o,    p1);
      check({tag, "_instr1"}, instr1_o, word_at(p1));
    end
    if (cnt >= 2) begin
      check({tag, "_pc2"},    pc2_o,    p2);
      check({tag, "_instr2"}, instr2_o, word_at(p2));
    end
    check({tag, "_valid1"}, {31'd0, valid1_o}, (cnt >= 1) ? 32'd1 : 32'd0);
    check({tag, "_valid2"}, {31'd0, valid2_o}, (cnt >= 2) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int          m_count;
    logic [31:0] m_head, m_pc;
    logic [1:0]  d, eff;

    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; deq_cnt_i = 2'd0;
    #7 reset = 1'b0;
    repeat (3) step();

    // 1: reset in the middle of a fill
    mid_cycle_reset("rst1");

    // 2: streaming with two pops per cycle
    deq_cnt_i = 2'd2;
    step(); check_q("stream1", 2, 32'h0001_0000, 32'h0001_0004);
    step(); check_q("stream2", 2, 32'h0001_0008, 32'h0001_000C);

    // 3: fill to full, then drain one at a time
    mid_cycle_reset("rst2");
    deq_cnt_i = 2'd0;
    step(); check_q("fill1", 2, 32'h0001_0000, 32'h0001_0004);
    step(); check_q("fill2", 4, 32'h0001_0000, 32'h0001_0004);
    check("fill2_a1", imem_a1_o, 32'h0001_0010);
    step(); check_q("full", 4, 32'h0001_0000, 32'h0001_0004);
    check("full_a1", imem_a1_o, 32'h0001_0010);
    deq_cnt_i = 2'd1;
    step(); check_q("deq1a", 3, 32'h0001_0004, 32'h0001_0008);
    check("deq1a_a1", imem_a1_o, 32'h0001_0010);
    step(); check_q("deq1b", 2, 32'h0001_0008, 32'h0001_000C);
    check("deq1b_a1", imem_a1_o, 32'h0001_0010);
    deq_cnt_i = 2'd0;
    step(); check_q("resume", 4, 32'h0001_0008, 32'h0001_000C);
    check("resume_a1", imem_a1_o, 32'h0001_0018);

    // 4: redirect beats a same-cycle dequeue; low bits of target dropped
    redirect_i = 1'b1; redirect_pc_i = 32'h0001_0022; deq_cnt_i = 2'd2;
    step(); check_q("redir", 0, 32'h0, 32'h0);
    check("redir_a1", imem_a1_o, 32'h0001_0020);
    check("redir_a2", imem_a2_o, 32'h0001_0024);
    redirect_i = 1'b0; deq_cnt_i = 2'd0;
    step(); check_q("redir_fetch", 2, 32'h0001_0020, 32'h0001_0024);

    // 5: over-asking dequeue on a single-entry queue
    deq_cnt_i = 2'd1;
    step(); check_q("odd3", 3, 32'h0001_0024, 32'h0001_0028);
    deq_cnt_i = 2'd2;
    step(); check_q("odd1", 1, 32'h0001_002C, 32'h0);
    deq_cnt_i = 2'd3;
    step(); check_q("underflow", 2, 32'h0001_0030, 32'h0001_0034);

    // 6: alternating pops across pointer wrap, tracked by a tiny occupancy model
    m_count = 2; m_head = 32'h0001_0030; m_pc = 32'h0001_0038;
    for (int i = 0; i < 10; i++) begin
      d = (i % 2 == 0) ? 2'd1 : 2'd2;
      deq_cnt_i = d;
      eff = (int'(d) > m_count) ? 2'(m_count) : d;
      m_head = m_head + 32'd4 * eff;
      if (m_count <= 2) begin
        m_count = m_count - int'(eff) + 2;
        m_pc    = m_pc + 32'd8;
      end else begin
        m_count = m_count - int'(eff);
      end
      step();
      check_q($sformatf("wrap%0d", i), m_count, m_head, m_head + 32'd4);
      check($sformatf("wrap%0d_a1", i), imem_a1_o, m_pc);
    end

    deq_cnt_i = 2'd0;
    mid_cycle_reset("rst3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
